ps2_key_tracker: RTL and testbench
==================================

PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of simultaneously held keys tracked (1..16).
REQ-002 SHALL have parameter CNT_W, default 8, meaning width of the press counter.
REQ-003 SHALL have port clk, input, 1, system clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port rx_data, input, 8, received PS/2 scan byte; qualified by rx_valid.
REQ-006 SHALL have port rx_valid, input, 1, one-cycle strobe: rx_data is a new byte.
REQ-007 SHALL have port ovf_clr, input, 1, synchronous clear of the overflow flag.
REQ-008 SHALL have port evt_valid, output, 1, one-cycle pulse: a key event has completed.
REQ-009 SHALL have port evt_make, output, 1, event type: 1 = make, 0 = break; valid with evt_valid.
REQ-010 SHALL have port evt_ext, output, 1, event carried the E0 prefix; valid with evt_valid.
REQ-011 SHALL have port evt_code, output, 8, final scan byte of the event; valid with evt_valid.
REQ-012 SHALL have port last_code, output, 8, code of the most recent new make; held for the display path.
REQ-013 SHALL have port held_cnt, output, $clog2(DEPTH+1), number of occupied table slots.
REQ-014 SHALL have port any_held, output, 1, equals (held_cnt != 0).
REQ-015 SHALL have port press_cnt, output, CNT_W, count of counted make events; wraps modulo 2^CNT_W.
REQ-016 SHALL have port overflow, output, 1, sticky: a new make was dropped because the table was full.

Function
REQ-017 SHALL implement parser FSM states WAIT, EXT, BRK, EXT_BRK; it advances only on cycles with rx_valid=1.
REQ-018 WAIT: E0 -> EXT; F0 -> BRK; any other byte -> make event (ext=0), stay WAIT.
REQ-019 EXT: F0 -> EXT_BRK; any other byte, including E0 -> make event (ext=1), go to WAIT.
REQ-020 BRK: any byte -> break event (ext=0), go to WAIT; EXT_BRK: any byte -> break event (ext=1), go to WAIT.
REQ-021 SHALL assert evt_valid and the evt_* fields on the cycle after the completing rx_valid byte (1-cycle latency); evt_* SHALL hold their values between events.
REQ-022 SHALL keep a held table of DEPTH entries, each {valid, ext, code}; a key is identified by the pair {ext, code}.
REQ-023 New make (key absent from table, free slot exists): SHALL write the lowest-index free slot, increment press_cnt, and load last_code; all three take effect with evt_valid.
REQ-024 Repeat make (key already present, typematic): SHALL leave the table unchanged and emit evt_valid; press_cnt and last_code are governed by REQ-034/035.
REQ-025 New make while the table is full: SHALL drop the key, set overflow, emit evt_valid, and leave press_cnt and last_code unchanged.
REQ-026 Break for a present key: SHALL clear that slot on the evt_valid cycle; a break for an absent key SHALL only emit evt_valid.
REQ-027 held_cnt and any_held SHALL reflect the table contents on the same cycle the table changes.
REQ-028 ovf_clr and an overflow-setting event in the same cycle: set SHALL win.
REQ-029 press_cnt SHALL wrap from 2^CNT_W-1 to 0 with no flag.
REQ-030 rx_valid SHALL be accepted on every cycle, including back-to-back cycles, with no bytes lost.

Reset
REQ-031 On rst low (asynchronous), the FSM SHALL go to WAIT and every table entry SHALL be invalidated.
REQ-032 On rst low, the following outputs SHALL be 0: evt_valid, evt_make, evt_ext, evt_code, last_code, held_cnt, press_cnt, overflow.
REQ-033 A reset that arrives mid-sequence (after E0 or F0) SHALL discard the partial sequence; the first byte after reset is parsed from WAIT.

Configuration
REQ-034 With macro PS2_TYPEMATIC_CNT_EN defined, each repeat make SHALL increment press_cnt and load last_code.
REQ-035 Without PS2_TYPEMATIC_CNT_EN, a repeat make SHALL change neither press_cnt nor last_code.

Verification
REQ-036 Bytes 1C, F0, 1C -> two evt_valid pulses (make 1C, then break 1C); press_cnt=1; last_code=1C; final held_cnt=0.
REQ-037 Bytes E0, 75, E0, F0, 75 -> make ext=1 code 75, then break ext=1 code 75; table empty after the break.
REQ-038 With DEPTH=4, makes 1C, 32, 21, 23, 2B -> held_cnt=4; overflow=1; press_cnt=4; 2B absent from the table.
REQ-039 Bytes 1C, 1C, 1C -> held_cnt=1; press_cnt=1 without the macro, 3 with PS2_TYPEMATIC_CNT_EN.
REQ-040 Bytes E0, then rst low for 1 cycle, then 1C -> make event with ext=0; press_cnt=1.
REQ-041 With CNT_W=2, five distinct make/break pairs -> press_cnt sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/ps2_key_tracker.sv
// PS/2 scan-code parser with a small held-key table, press counter and overflow flag.
// Optional macro PS2_TYPEMATIC_CNT_EN: typematic repeat makes also bump press_cnt/last_code.
module ps2_key_tracker #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  input  logic                       ovf_clr,
  output logic                       evt_valid,
  output logic                       evt_make,
  output logic                       evt_ext,
  output logic [7:0]                 evt_code,
  output logic [7:0]                 last_code,
  output logic [$clog2(DEPTH+1)-1:0] held_cnt,
  output logic                       any_held,
  output logic [CNT_W-1:0]           press_cnt,
  output logic                       overflow
);

  localparam int HW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_WAIT    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              done_s, make_s, ext_s;

  logic [DEPTH-1:0]  vld_q;
  logic [DEPTH-1:0]  ext_q;
  logic [7:0]        code_q [DEPTH];

  logic              hit_s, free_s;
  logic [IW-1:0]     hit_idx_s, free_idx_s;
  logic              new_make_s, drop_s, clr_s, count_s;
  logic [HW-1:0]     held_s;

  logic              evt_valid_q, evt_make_q, evt_ext_q;
  logic [7:0]        evt_code_q, last_code_q;
  logic [CNT_W-1:0]  press_cnt_q;
  logic              overflow_q;

  // Parser state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Parser next state and event decode
  always_comb begin
    state_d = state_q;
    done_s  = 1'b0;
    make_s  = 1'b0;
    ext_s   = 1'b0;
    if (rx_valid) begin
      case (state_q)
        S_WAIT: begin
          if (rx_data == 8'hE0) begin
            state_d = S_EXT;
          end else if (rx_data == 8'hF0) begin
            state_d = S_BRK;
          end else begin
            done_s = 1'b1;
            make_s = 1'b1;
          end
        end
        S_EXT: begin
          ext_s = 1'b1;
          if (rx_data == 8'hF0) begin
            state_d = S_EXT_BRK;
          end else begin
            done_s  = 1'b1;
            make_s  = 1'b1;
            state_d = S_WAIT;
          end
        end
        S_BRK: begin
          done_s  = 1'b1;
          state_d = S_WAIT;
        end
        S_EXT_BRK: begin
          done_s  = 1'b1;
          ext_s   = 1'b1;
          state_d = S_WAIT;
        end
        default: begin
          state_d = S_WAIT;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Table lookup: matching slot, lowest free slot, occupancy count
  always_comb begin
    hit_s      = 1'b0;
    hit_idx_s  = {IW{1'b0}};
    free_s     = 1'b0;
    free_idx_s = {IW{1'b0}};
    held_s     = {HW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (ext_q[i] == ext_s) && (code_q[i] == rx_data)) begin
        hit_s     = 1'b1;
        hit_idx_s = IW'(i);
      end else begin
        hit_s     = hit_s;
      end
      held_s = held_s + HW'(vld_q[i]);
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!vld_q[i]) begin
        free_s     = 1'b1;
        free_idx_s = IW'(i);
      end else begin
        free_s     = free_s;
      end
    end
  end

  assign new_make_s = done_s & make_s & ~hit_s & free_s;
  assign drop_s     = done_s & make_s & ~hit_s & ~free_s;
  assign clr_s      = done_s & ~make_s & hit_s;

`ifdef PS2_TYPEMATIC_CNT_EN
  logic rep_make_s;
  assign rep_make_s = done_s & make_s & hit_s;
  assign count_s    = new_make_s | rep_make_s;
`else
  assign count_s    = new_make_s;
`endif

  // Held-key table: insert new makes, remove broken keys
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= {DEPTH{1'b0}};
      ext_q <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        code_q[i] <= 8'h00;
      end
    end else if (new_make_s) begin
      vld_q[free_idx_s]  <= 1'b1;
      ext_q[free_idx_s]  <= ext_s;
      code_q[free_idx_s] <= rx_data;
    end else if (clr_s) begin
      vld_q[hit_idx_s] <= 1'b0;
    end else begin
      vld_q <= vld_q;
    end
  end

  // Event outputs, counters and sticky overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      evt_valid_q <= 1'b0;
      evt_make_q  <= 1'b0;
      evt_ext_q   <= 1'b0;
      evt_code_q  <= 8'h00;
      last_code_q <= 8'h00;
      press_cnt_q <= {CNT_W{1'b0}};
      overflow_q  <= 1'b0;
    end else begin
      evt_valid_q <= done_s;
      if (done_s) begin
        evt_make_q <= make_s;
        evt_ext_q  <= ext_s;
        evt_code_q <= rx_data;
      end else begin
        evt_code_q <= evt_code_q;
      end
      if (count_s) begin
        press_cnt_q <= press_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        last_code_q <= rx_data;
      end else begin
        press_cnt_q <= press_cnt_q;
      end
      // A drop in the same cycle as a clear request keeps the flag set
      if (drop_s) begin
        overflow_q <= 1'b1;
      end else if (ovf_clr) begin
        overflow_q <= 1'b0;
      end else begin
        overflow_q <= overflow_q;
      end
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_make  = evt_make_q;
  assign evt_ext   = evt_ext_q;
  assign evt_code  = evt_code_q;
  assign last_code = last_code_q;
  assign held_cnt  = held_s;
  assign any_held  = (held_s != {HW{1'b0}});
  assign press_cnt = press_cnt_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: directed sequences plus random byte streams
// checked against a key-set reference model.
module tb_ps2_key_tracker;

  localparam int DEPTH = 4;
  localparam int CNT_W = 2;
  localparam int HW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [7:0]       rx_data = 8'h00;
  logic             rx_valid = 1'b0;
  logic             ovf_clr = 1'b0;
  logic             evt_valid, evt_make, evt_ext;
  logic [7:0]       evt_code, last_code;
  logic [HW-1:0]    held_cnt;
  logic             any_held;
  logic [CNT_W-1:0] press_cnt;
  logic             overflow;

  ps2_key_tracker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .ovf_clr(ovf_clr),
    .evt_valid(evt_valid), .evt_make(evt_make), .evt_ext(evt_ext), .evt_code(evt_code),
    .last_code(last_code), .held_cnt(held_cnt), .any_held(any_held),
    .press_cnt(press_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       make;
    bit       ext;
    int       code;
    int       last;
    int       held;
    int       pcnt;
    bit       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // reference model: pending prefixes, set of held keys, counters
  bit   m_pext, m_pbrk, m_ovf;
  int   m_held[$];
  int   m_cnt;
  int   m_last;

  task automatic check(input string name, input int act, input int expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_pext = 1'b0; m_pbrk = 1'b0; m_ovf = 1'b0;
    m_held.delete();
    m_cnt = 0; m_last = 0;
  endtask

  task automatic model_key(input bit mk, input bit ex, input int c, input bit clr);
    int   key;
    int   pos;
    bit   set_ovf;
    exp_t e;
    key = (int'(ex) << 8) | c;
    pos = -1;
    set_ovf = 1'b0;
    foreach (m_held[i]) if (m_held[i] == key) pos = i;
    if (mk) begin
      if (pos >= 0) begin
`ifdef PS2_TYPEMATIC_CNT_EN
        m_cnt  = (m_cnt + 1) % (1 << CNT_W);
        m_last = c;
`endif
      end else if (m_held.size() < DEPTH) begin
        m_held.push_back(key);
        m_cnt  = (m_cnt + 1) % (1 << CNT_W);
        m_last = c;
      end else begin
        set_ovf = 1'b1;
      end
    end else if (pos >= 0) begin
      m_held.delete(pos);
    end
    if (set_ovf) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    e.make = mk; e.ext = ex; e.code = c; e.last = m_last;
    e.held = m_held.size(); e.pcnt = m_cnt; e.ovf = m_ovf;
    exp_q.push_back(e);
  endtask

  task automatic model_cycle(input bit v, input int b, input bit clr);
    if (!v) begin
      if (clr) m_ovf = 1'b0;
    end else if (m_pbrk) begin
      model_key(1'b0, m_pext, b, clr);
      m_pext = 1'b0; m_pbrk = 1'b0;
    end else if (b == 'hF0) begin
      m_pbrk = 1'b1;
      if (clr) m_ovf = 1'b0;
    end else if (b == 'hE0 && !m_pext) begin
      m_pext = 1'b1;
      if (clr) m_ovf = 1'b0;
    end else begin
      model_key(1'b1, m_pext, b, clr);
      m_pext = 1'b0;
    end
  endtask

  task automatic drive(input bit v, input int b, input bit clr);
    @(posedge clk); #1;
    rx_valid = v;
    rx_data  = 8'(b);
    ovf_clr  = clr;
    model_cycle(v, b, clr);
  endtask

  task automatic send_seq(input int bytes[$]);
    foreach (bytes[i]) drive(1'b1, bytes[i], 1'b0);
    drive(1'b0, 0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b0, 0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check("rst_evt_valid", int'(evt_valid), 0);
    check("rst_evt_make", int'(evt_make), 0);
    check("rst_evt_ext", int'(evt_ext), 0);
    check("rst_evt_code", int'(evt_code), 0);
    check("rst_last_code", int'(last_code), 0);
    check("rst_held_cnt", int'(held_cnt), 0);
    check("rst_any_held", int'(any_held), 0);
    check("rst_press_cnt", int'(press_cnt), 0);
    check("rst_overflow", int'(overflow), 0);
    rst = 1'b1;
  endtask

  // monitor: every evt_valid pulse pops one expected event
  always @(negedge clk) begin
    if (rst && evt_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_evt", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("evt_make", int'(evt_make), int'(e.make));
        check("evt_ext", int'(evt_ext), int'(e.ext));
        check("evt_code", int'(evt_code), e.code);
        check("last_code", int'(last_code), e.last);
        check("held_cnt", int'(held_cnt), e.held);
        check("any_held", int'(any_held), int'(e.held != 0));
        check("press_cnt", int'(press_cnt), e.pcnt);
        check("overflow", int'(overflow), int'(e.ovf));
      end
    end
  end

  int codes[6] = '{'h1C, 'h32, 'h21, 'h23, 'h2B, 'h75};

  initial begin
    int wait_cyc;
    model_reset();
    do_reset();
    send_seq('{'h1C, 'hF0, 'h1C});
    send_seq('{'hE0, 'h75, 'hE0, 'hF0, 'h75});
    send_seq('{'h1C, 'h32, 'h21, 'h23, 'h2B});
    send_seq('{'hF0, 'h2B});
    drive(1'b1, 'h2B, 1'b1);
    drive(1'b0, 0, 1'b1);
    do_reset();
    send_seq('{'h1C, 'h1C, 'h1C});
    do_reset();
    send_seq('{'hE0});
    do_reset();
    send_seq('{'h1C});
    do_reset();
    for (int k = 0; k < 5; k++) send_seq('{codes[k], 'hF0, codes[k]});
    for (int n = 0; n < 4000; n++) begin
      int p;
      int b;
      p = $urandom_range(0, 9);
      if (p < 2) b = 'hE0;
      else if (p < 4) b = 'hF0;
      else b = codes[$urandom_range(0, 5)];
      if ($urandom_range(0, 999) == 0) do_reset();
      else drive($urandom_range(0, 99) < 80, b, $urandom_range(0, 19) == 0);
    end
    drive(1'b0, 0, 1'b0);
    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    check("pending_events_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
